// File: rtl/i_delay_tap_ctrl_pkg.sv
// rtl/i_delay_tap_ctrl_pkg.sv - shared types and widths for the I_DELAY tap controller
// Purpose: tap width, step counter width and FSM state encoding.
// Ports: none (package).
package i_delay_tap_ctrl_pkg;

  localparam int TAP_W  = 6;
  localparam int STEP_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADJ,
    ST_SETTLE,
    ST_CHECK
  } state_t;

endpackage

// File: rtl/dly_settle_timer.sv
// rtl/dly_settle_timer.sv - settle interval down-counter for the tap controller
// Purpose: loads SETTLE_CYCLES when start is high, counts down, flags the last settle cycle.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   start  - high during LOAD/ADJ; the counter loads on that cycle's exit edge
//   expire - high during the final settle cycle
module dly_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (start) begin
      cnt <= 8'(SETTLE_CYCLES);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Count reads SETTLE_CYCLES..1 across the settle window, so 1 marks its last cycle.
  assign expire = (cnt == 8'd1);

endmodule

// File: rtl/i_delay_tap_ctrl.sv
// rtl/i_delay_tap_ctrl.sv - closed-loop I_DELAY tap stepping controller
// Purpose: accepts a target tap, optionally pulses DLY_LOAD, then steps DLY_ADJ one tap
//          at a time with a settle interval until DLY_TAP_VALUE matches; reports done/err.
// Ports:
//   clk_i, rst_ni                    - clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o          - command handshake (ready only in IDLE)
//   cmd_load_i, cmd_tap_i            - load request and target tap
//   dly_ld_o, dly_adj_o, dly_incdec_o - drive I_DELAY DLY_LOAD / DLY_ADJ / DLY_INCDEC
//   dly_tap_val_i                    - I_DELAY DLY_TAP_VALUE
//   busy_o, done_o, err_o            - status; done/err are one-cycle pulses
module i_delay_tap_ctrl
  import i_delay_tap_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_STEPS     = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_load_i,
  input  logic [TAP_W-1:0] cmd_tap_i,
  output logic             dly_ld_o,
  output logic             dly_adj_o,
  output logic             dly_incdec_o,
  input  logic [TAP_W-1:0] dly_tap_val_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_t              state;
  logic [TAP_W-1:0]    target;
  logic [TAP_W-1:0]    snap;
  logic [STEP_W-1:0]   steps;
  logic                adj_last;
  logic                timer_start;
  logic                settle_expire;

  assign cmd_ready_o = (state == ST_IDLE);
  assign busy_o      = (state != ST_IDLE);
  assign timer_start = (state == ST_LOAD) || (state == ST_ADJ);

  dly_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .start (timer_start),
    .expire(settle_expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      target       <= '0;
      snap         <= '0;
      steps        <= '0;
      adj_last     <= 1'b0;
      dly_ld_o     <= 1'b0;
      dly_adj_o    <= 1'b0;
      dly_incdec_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      // Pulse outputs are set on the edge entering their state, so they are high for
      // exactly that state's single cycle.
      dly_ld_o  <= 1'b0;
      dly_adj_o <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            target   <= cmd_tap_i;
            steps    <= '0;
            adj_last <= 1'b0;
            if (cmd_load_i) begin
              state    <= ST_LOAD;
              dly_ld_o <= 1'b1;
            end else begin
              state <= ST_CHECK;
            end
          end
        end
        ST_LOAD: state <= ST_SETTLE;
        ST_ADJ: begin
          if (steps != STEP_W'(MAX_STEPS)) steps <= steps + STEP_W'(1);
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_expire) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (dly_tap_val_i == target) begin
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end else if (adj_last && (dly_tap_val_i == snap)) begin
            // Tap did not move after an adjust: stuck primitive or saturated at 0/63.
            err_o <= 1'b1;
            state <= ST_IDLE;
          end else if (steps == STEP_W'(MAX_STEPS)) begin
            err_o <= 1'b1;
            state <= ST_IDLE;
          end else begin
            dly_incdec_o <= (target > dly_tap_val_i);
            snap         <= dly_tap_val_i;
            adj_last     <= 1'b1;
            dly_adj_o    <= 1'b1;
            state        <= ST_ADJ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i_delay_tap_ctrl.sv
// tb/tb_i_delay_tap_ctrl.sv - directed self-checking bench for i_delay_tap_ctrl
module tb_i_delay_tap_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [5:0] cmd_tap;
  logic       dly_ld;
  logic       dly_adj;
  logic       dly_incdec;
  logic [5:0] mtap;
  logic       busy;
  logic       done;
  logic       err;

  logic       preset_en;
  logic [5:0] preset_val;
  logic       stuck;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   done_c;
    int   err_c;
    int   n_adj;
    int   n_ld;
    int   gap_min;
    int   gap_max;
    logic inc_all;
    logic dec_all;
    logic bad;
    logic rdy_seen;
  } res_t;

  res_t r;
  res_t r2;

  i_delay_tap_ctrl #(
    .SETTLE_CYCLES(4),
    .MAX_STEPS    (64)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_load_i   (cmd_load),
    .cmd_tap_i    (cmd_tap),
    .dly_ld_o     (dly_ld),
    .dly_adj_o    (dly_adj),
    .dly_incdec_o (dly_incdec),
    .dly_tap_val_i(mtap),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural I_DELAY: load to DELAY=10, +/-1 per adjust, saturating, optionally frozen.
  always @(posedge clk) begin
    if (preset_en) mtap <= preset_val;
    else if (dly_ld) mtap <= 6'd10;
    else if (dly_adj && !stuck) begin
      if (dly_incdec) begin
        if (mtap != 6'd63) mtap <= mtap + 6'd1;
      end else if (mtap != 6'd0) begin
        mtap <= mtap - 6'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_tap(input logic [5:0] v);
    @(negedge clk);
    preset_en  = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Watches cycles 1.. after a handshake until done/err or the cycle budget runs out.
  task automatic monitor(output res_t m);
    int last;
    m.done_c = -1; m.err_c = -1; m.n_adj = 0; m.n_ld = 0;
    m.gap_min = 1000; m.gap_max = 0;
    m.inc_all = 1'b1; m.dec_all = 1'b1; m.bad = 1'b0; m.rdy_seen = 1'b0;
    last = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (dly_ld && dly_adj) m.bad = 1'b1;
      if (done && err) m.bad = 1'b1;
      if (dly_ld) m.n_ld++;
      if (dly_adj) begin
        m.n_adj++;
        if (dly_incdec) m.dec_all = 1'b0;
        else m.inc_all = 1'b0;
        if (last >= 0) begin
          if (c - last < m.gap_min) m.gap_min = c - last;
          if (c - last > m.gap_max) m.gap_max = c - last;
        end
        last = c;
      end
      if (err) begin m.err_c = c; break; end
      if (done) begin m.done_c = c; break; end
      if (cmd_ready) m.rdy_seen = 1'b1;
    end
  endtask

  task automatic issue(input logic ld, input logic [5:0] tap, output res_t m);
    @(negedge clk);
    chk("ready_at_cycle0", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_tap   = tap;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    monitor(m);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_tap = 6'd0;
    preset_en = 1'b0; preset_val = 6'd0; stuck = 1'b0;

    // Reset state
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {dly_ld, dly_adj, dly_incdec, done, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Target equals current tap
    set_tap(6'd10);
    issue(1'b0, 6'd10, r);
    chk("eq_done_cycle", r.done_c, 2);
    chk("eq_adj_count", r.n_adj, 0);
    chk("eq_err", r.err_c, -1);

    // Increment 10 -> 13
    issue(1'b0, 6'd13, r);
    chk("inc_done_cycle", r.done_c, 20);
    chk("inc_adj_count", r.n_adj, 3);
    chk("inc_dir", r.inc_all, 1);
    chk("inc_gap_min", r.gap_min, 6);
    chk("inc_gap_max", r.gap_max, 6);
    chk("inc_no_overlap", r.bad, 0);
    chk("inc_final_tap", mtap, 13);

    // Load then decrement 40 -> (load 10) -> 8
    set_tap(6'd40);
    issue(1'b1, 6'd8, r);
    chk("ld_load_count", r.n_ld, 1);
    chk("ld_adj_count", r.n_adj, 2);
    chk("ld_dir", r.dec_all, 1);
    chk("ld_done_cycle", r.done_c, 19);
    chk("ld_no_overlap", r.bad, 0);
    chk("ld_final_tap", mtap, 8);

    // Stuck tap at 5
    set_tap(6'd5);
    stuck = 1'b1;
    issue(1'b0, 6'd9, r);
    chk("stuck_adj_count", r.n_adj, 1);
    chk("stuck_err_cycle", r.err_c, 8);
    chk("stuck_no_done", r.done_c, -1);
    chk("stuck_tap", mtap, 5);
    stuck = 1'b0;

    // Reset during SETTLE (cycle 4 of a 5 -> 20 run)
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_tap = 6'd20;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_incdec", dly_incdec, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pulses", {dly_ld, dly_adj, dly_incdec, done, err}, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_tap_kept", mtap, 6);
    issue(1'b0, 6'd8, r);
    chk("post_rst_done_cycle", r.done_c, 14);
    chk("post_rst_tap", mtap, 8);

    // Busy protection: valid held with a new tap during the run
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_tap = 6'd10;
    @(posedge clk);
    #1 cmd_tap = 6'd12;
    monitor(r);
    chk("busy_done_cycle", r.done_c, 14);
    chk("busy_not_ready", r.rdy_seen, 0);
    chk("busy_tap_first", mtap, 10);
    chk("busy_ready_at_done", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    monitor(r2);
    chk("busy_second_done", r2.done_c, 14);
    chk("busy_second_adj", r2.n_adj, 2);
    chk("busy_second_tap", mtap, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_delay_tap_ctrl.md
# i_delay_tap_ctrl

Sequential controller sitting directly upstream of the I_DELAY primitive: it accepts tap-setting commands and drives I_DELAY's DLY_LOAD, DLY_ADJ and DLY_INCDEC inputs. It closes the loop on DLY_TAP_VALUE, stepping one tap at a time with a settle interval until the requested tap is reached. It reports completion, or an error if the tap fails to move. One instance serves one I_DELAY.

## Interface
- SETTLE_CYCLES, 4: idle cycles after each DLY_LOAD/DLY_ADJ pulse before DLY_TAP_VALUE is sampled; legal range 1..255.
- MAX_STEPS, 64: adjust pulses allowed per command before error.
- clk_i  input  1  clock; same clock as I_DELAY CLK_IN.
- rst_ni  input  1  reset, asynchronous, active-low.
- cmd_valid_i  input  1  command request.
- cmd_ready_o  output  1  high only in IDLE.
- cmd_load_i  input  1  1 = pulse DLY_LOAD (return to the primitive's configured DELAY) before stepping.
- cmd_tap_i  input  6  target tap 0..63.
- dly_ld_o  output  1  to I_DELAY DLY_LOAD, one-cycle pulse.
- dly_adj_o  output  1  to I_DELAY DLY_ADJ, one-cycle pulse = one tap step.
- dly_incdec_o  output  1  to I_DELAY DLY_INCDEC; 1 = increment.
- dly_tap_val_i  input  6  from I_DELAY DLY_TAP_VALUE.
- busy_o  output  1  high whenever state is not IDLE.
- done_o  output  1  one-cycle pulse: target reached.
- err_o  output  1  one-cycle pulse: step failure.

## Operation
- States: IDLE, LOAD, ADJ, SETTLE, CHECK.
- IDLE: cmd_ready_o=1. On cmd_valid_i&&cmd_ready_o, register cmd_tap_i and cmd_load_i, clear the step counter, then go to LOAD if load=1, else CHECK.
- LOAD: dly_ld_o=1 for this cycle, then go to SETTLE.
- SETTLE: counter runs SETTLE_CYCLES cycles, then go to CHECK.
- CHECK: compare dly_tap_val_i against the target.
  - Equal: done_o=1 next cycle, go to IDLE.
  - Previous action was ADJ and tap equals the pre-ADJ snapshot: err_o=1 next cycle, go to IDLE. This covers a stuck tap or I_DELAY saturation.
  - Step counter == MAX_STEPS: err_o=1, go to IDLE.
  - Otherwise: set dly_incdec_o=(target>tap), snapshot the tap, and go to ADJ.
- ADJ: dly_adj_o=1 for one cycle. dly_incdec_o holds its CHECK-set value through ADJ and SETTLE. Step counter +1. Then go to SETTLE.
- All outputs are registered except cmd_ready_o and busy_o, which decode the state.
- cmd_valid_i while busy: ignored; the requester holds.
- Width rules: 6-bit unsigned tap compare. The step counter is 7 bits and saturates at MAX_STEPS.
- Reset, including mid-operation: state=IDLE; dly_ld_o, dly_adj_o, dly_incdec_o, done_o, err_o all 0; counters 0. The I_DELAY tap is not restored. cmd_ready_o=1 and busy_o=0 while in reset.

## Timing
- Cycle 0 is the handshake cycle. k adjust steps, no load: done_o is high in cycle 2+k*(SETTLE_CYCLES+2).
- Load adds 1+SETTLE_CYCLES cycles.
- At most one DLY_ADJ pulse per SETTLE_CYCLES+2 cycles.
- dly_ld_o and dly_adj_o are never high together.
- cmd_ready_o rises in the same cycle as done_o/err_o. A back-to-back command can be accepted in that cycle.
- done_o and err_o are never high together.

## Structure
- Package i_delay_tap_ctrl_pkg holds:
  - TAP_W=6;
  - the state enum type;
  - the step counter width.
- Sub-module dly_settle_timer: load on LOAD/ADJ exit, count SETTLE_CYCLES down, assert an expire pulse.
- Top level holds the FSM, target/snapshot registers, and step counter.

## Test plan
- Bench uses a behavioural I_DELAY model: tap register, ±1 on DLY_ADJ, saturates 0/63, DLY_LOAD→DELAY=10, SETTLE_CYCLES=4.
- Target equals current: tap=10, cmd_tap=10, load=0 -> no dly_adj_o; done_o in cycle 2.
- Increment: tap=10, cmd_tap=13 -> exactly 3 dly_adj_o pulses with incdec=1, 6 cycles apart; done_o in cycle 20; final tap 13.
- Load+decrement: tap=40, load=1, cmd_tap=8 -> one dly_ld_o (tap→10), then 2 dec pulses; done_o in cycle 19.
- Stuck tap: model frozen at 5, cmd_tap=9 -> one dly_adj_o; err_o in cycle 8; no done_o.
- Reset mid-SETTLE: deassert rst_ni while stepping -> all pulse outputs 0 immediately; cmd_ready_o=1; the next command completes normally from the model's current tap.
- Busy protection: cmd_valid_i held high with a new tap during a run -> not accepted until the done_o cycle; accepted in that cycle.
